// File: rtl/norm_pkg.sv
// Shared state encoding, default input width and msb-index helper
// for the multi-channel normalising divider.
package norm_pkg;

    localparam int IN_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DIVIDE,
        STORE
    } state_t;

    function automatic int msb_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/norm_div_core.sv
// Single-channel non-restoring divider, one quotient bit per step.
// The dividend register shifts left and collects quotient bits at its LSB.
module norm_div_core #(
    parameter int S  = 8,
    parameter int NB = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          init,
    input  logic          step,
    input  logic [NB-1:0] dividend,
    input  logic [S-1:0]  divisor,
    output logic [NB-1:0] quot
);
    // |rem| < 2*divisor, so the shifted remainder needs S+3 signed bits
    localparam int RW = S + 3;

    logic [RW-1:0] rem;
    logic [RW-1:0] sh;
    logic [RW-1:0] nr;
    logic [S-1:0]  dsr;

    always_comb begin
        sh = {rem[RW-2:0], quot[NB-1]};
        nr = rem[RW-1] ? sh + RW'(dsr) : sh - RW'(dsr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quot <= '0;
            rem  <= '0;
            dsr  <= '0;
        end else if (en) begin
            if (init) begin
                quot <= dividend;
                rem  <= '0;
                dsr  <= divisor;
            end else if (step) begin
                quot <= {quot[NB-2:0], ~nr[RW-1]};
                rem  <= nr;
            end
        end
    end

endmodule

// File: rtl/norm_div_multi.sv
// Time-multiplexed normalising divider over CH channels.
// Define NORM_DIV_ROUND_EN for round-half-up quotients (one extra step).
module norm_div_multi
    import norm_pkg::*;
#(
    parameter int CH   = 4,
    parameter int IN_W = IN_W_DEF,
    parameter int S    = 8,
    parameter int FRAC = 8
) (
    input  logic                 MHz10,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic [CH*IN_W-1:0]   count_flat,
    input  logic [CH*IN_W-1:0]   max_flat,
    output logic [CH*(S+FRAC)-1:0] quot_flat,
    output logic [CH-1:0]        ovf,
    output logic [CH-1:0]        div0,
    output logic                 ready,
    output logic                 done
);
    localparam int QW = S + FRAC;
`ifdef NORM_DIV_ROUND_EN
    localparam int NB = QW + 1;
`else
    localparam int NB = QW;
`endif
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;
    localparam int IW = $clog2(NB + 1);

    state_t              state;
    logic [CW-1:0]       ch;
    logic [IW-1:0]       it;
    logic                fin;
    logic                done_r;
    logic                byp_dz;
    logic                byp_ov;
    logic [CH*IN_W-1:0]  cnt_r;
    logic [CH*IN_W-1:0]  max_r;

    logic [IN_W-1:0]     cur_c;
    logic [IN_W-1:0]     cur_m;
    int                  top;
    logic [S-1:0]        cw;
    logic [S-1:0]        mw;
    logic                dz_c;
    logic                ov_c;
    logic [NB-1:0]       cq;
    logic [QW-1:0]       res;

    always_comb begin
        cur_c = cnt_r[ch*IN_W +: IN_W];
        cur_m = max_r[ch*IN_W +: IN_W];
        top   = msb_idx(32'(cur_m));
        if (top < S - 1) top = S - 1;
        cw    = S'(cur_c >> (top - S + 1));
        mw    = S'(cur_m >> (top - S + 1));
        dz_c  = (cur_m == '0);
        ov_c  = !dz_c && ((cur_c >> (top + 1)) != '0);
    end

`ifdef NORM_DIV_ROUND_EN
    logic [QW:0] rq;
    always_comb begin
        rq  = {1'b0, cq[NB-1:1]} + (QW+1)'(cq[0]);
        res = rq[QW] ? '1 : rq[QW-1:0];
    end
`else
    always_comb res = cq;
`endif

    norm_div_core #(
        .S  (S),
        .NB (NB)
    ) u_core (
        .clk      (MHz10),
        .rst      (rst),
        .en       (en),
        .init     (state == LOAD),
        .step     ((state == DIVIDE) && !byp_dz && !byp_ov),
        .dividend (NB'(cw) << (NB - S)),
        .divisor  (mw),
        .quot     (cq)
    );

    assign ready = (state == IDLE) && en && !fin && !done_r;
    assign done  = done_r && en;

    always_ff @(posedge MHz10) begin
        if (rst) begin
            state     <= IDLE;
            ch        <= '0;
            it        <= '0;
            fin       <= 1'b0;
            done_r    <= 1'b0;
            byp_dz    <= 1'b0;
            byp_ov    <= 1'b0;
            cnt_r     <= '0;
            max_r     <= '0;
            quot_flat <= '0;
            ovf       <= '0;
            div0      <= '0;
        end else if (en) begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fin) begin
                        fin    <= 1'b0;
                        done_r <= 1'b1;
                    end else if (start && !done_r) begin
                        cnt_r <= count_flat;
                        max_r <= max_flat;
                        ch    <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    byp_dz <= dz_c;
                    byp_ov <= ov_c;
                    it     <= '0;
                    state  <= DIVIDE;
                end
                DIVIDE: begin
                    it <= it + 1'b1;
                    if (it == IW'(NB - 1)) state <= STORE;
                end
                STORE: begin
                    quot_flat[ch*QW +: QW] <= (byp_dz || byp_ov) ? '1 : res;
                    ovf[ch]  <= byp_ov;
                    div0[ch] <= byp_dz;
                    if (ch == CW'(CH - 1)) begin
                        state <= IDLE;
                        fin   <= 1'b1;
                    end else begin
                        ch    <= ch + 1'b1;
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
